frame_sys_ctrl: RTL and testbench
=================================

Name: frame_sys_ctrl

Overview:
- Parametrised command-frame controller in the Ref_clk domain.
- Sits between the synchronised UART-RX byte stream and the register file, gated ALU and async TX FIFO.
- Decodes command frames, executes register/ALU operations and queues multi-byte responses into the FIFO.
- Relative to the existing controller, adds parametrised data/ALU widths, burst register read, inter-byte timeout, unknown-command/overrun error reporting and FIFO-full backpressure.

Parameters:
DATA_W, 8, byte/register width
ADDR_W, 4, register-file address width
FUN_W, 4, ALU function code width
ALU_W, 16, ALU result width; must be a multiple of DATA_W; RES_BYTES = ALU_W/DATA_W
TO_W, 16, timeout counter width
TIMEOUT, 16'd5000, cycles allowed between frame bytes and for ALU completion

Ports:
clk  in  1  Ref_clk
rst_n  in  1  asynchronous active-low reset
rx_data  in  DATA_W  synchronised RX byte
rx_valid  in  1  one-cycle strobe, rx_data valid
rf_wr_en  out  1  register write strobe
rf_rd_en  out  1  register read strobe
rf_addr  out  ADDR_W  register address
rf_wr_data  out  DATA_W  register write data
rf_rd_data  in  DATA_W  register read data
rf_rd_valid  in  1  read data valid, one cycle after rf_rd_en
alu_en  out  1  ALU enable
alu_fun  out  FUN_W  ALU function
alu_out  in  ALU_W  ALU result
alu_valid  in  1  ALU result valid
clk_gate_en  out  1  ALU clock-gate enable
clk_div_en  out  1  UART clock dividers enable
fifo_wr_data  out  DATA_W  byte to TX FIFO
fifo_wr_inc  out  1  FIFO push strobe
fifo_full  in  1  FIFO full
frame_err  out  1  one-cycle error pulse
err_code  out  2  error cause, 1=unknown cmd, 2=timeout, 3=overrun; held until next error

Behaviour:
- Reset: every output is 0, except clk_div_en, which is 1 one cycle after reset release and remains 1. The FSM is in IDLE.
- Command bytes (low 8 bits of rx_data; DATA_W >= 8):
  - 0xAA: write; frame AA, addr, data.
  - 0xBB: read; frame BB, addr.
  - 0xCC: ALU with operands; frame CC, A, B, fun. A is written to address 0 and B to address 1 on consecutive cycles.
  - 0xDD: ALU without operands; frame DD, fun.
  - 0xEE: burst read; frame EE, addr, N. N = 0 means no response.
- Unknown command byte in IDLE: frame_err pulses with err_code=1; the FSM stays in IDLE.
- States: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, GET_CNT, RF_WR, RF_RD, RF_WAIT, ALU_GATE, ALU_WAIT, PUSH.
- Address is taken from the low ADDR_W bits of the address byte.
- Write: rf_wr_en is high for exactly 1 cycle, the cycle after the data byte is received.
- Read:
  - rf_rd_en is high for 1 cycle.
  - The byte is captured on rf_rd_valid and then pushed.
  - Burst read repeats this N times with addr+i, wrapping modulo 2^ADDR_W.
  - Each byte is pushed before the next read is issued.
- ALU:
  - clk_gate_en rises in ALU_GATE; alu_en rises on the following cycle.
  - alu_en and clk_gate_en stay high until alu_valid is seen.
  - alu_out is then captured and both signals drop on the next cycle.
  - RES_BYTES bytes are pushed, least-significant byte first.
- Push:
  - fifo_wr_inc is high only in cycles where fifo_full = 0; one byte is pushed per such cycle.
  - If fifo_full is asserted, the byte is held and the push retries with no data loss.
  - The FSM returns to IDLE after the last byte.
- Timeout:
  - The counter resets on each accepted byte, on entry to ALU_GATE, and on alu_valid.
  - In any GET_* state or in ALU_WAIT, the counter reaching TIMEOUT triggers: frame_err pulse with err_code=2, alu_en and clk_gate_en forced low, return to IDLE.
  - No partial register write occurs on a timeout.
- Overrun: rx_valid in any non-IDLE, non-GET_* state discards the byte and pulses frame_err with err_code=3. The operation in progress continues unaffected.
- Simultaneous events:
  - rx_valid in the same cycle as a timeout expiry: the timeout wins and the byte is discarded.
  - frame_err pulses at most once per cycle.
- Reset mid-operation: immediate return to IDLE with all strobes low. A partial frame is abandoned.

Test Plan:
- RX AA,05,3C -> rf_wr_en for 1 cycle with rf_addr=5, rf_wr_data=0x3C; no FIFO push.
- RX BB,02 with reg2=0x81 -> rf_rd_en 1 cycle, then one push of 0x81.
- RX CC,0A,03,00 with alu_out=0x000D -> writes to addr0=0x0A and addr1=0x03; clk_gate_en precedes alu_en by 1 cycle; pushes 0x0D then 0x00.
- RX EE,0E,03 with fifo_full held high for 10 cycles mid-burst -> pushes reg14, reg15, reg0 in order; no byte lost or duplicated.
- RX AA,05 then silence for TIMEOUT cycles -> frame_err pulse with err_code=2; no rf_wr_en; next frame AA,01,FF executes normally.
- RX 0x55 -> frame_err with err_code=1; RX byte during PUSH -> err_code=3 and the push completes intact.

Source files
------------

// File: rtl/frame_sys_ctrl.sv
// Command-frame controller: decodes RX byte frames into register-file and ALU operations
// and queues the response bytes into the TX FIFO, with timeout/overrun/unknown-command errors.
//
// state    | meaning
// IDLE     | waiting for a command byte
// GET_ADDR | waiting for the address byte (AA/BB/EE)
// GET_DATA | waiting for the write data byte (AA)
// GET_OPA  | waiting for operand A (CC)
// GET_OPB  | waiting for operand B (CC)
// GET_FUN  | waiting for the ALU function byte (CC/DD)
// GET_CNT  | waiting for the burst length (EE)
// RF_WR    | register write strobe (CC: two cycles, A->0 then B->1)
// RF_RD    | register read strobe
// RF_WAIT  | waiting for rf_rd_valid
// ALU_GATE | ALU clock gate opened, alu_en follows next cycle
// ALU_WAIT | alu_en high, waiting for alu_valid
// PUSH     | draining result bytes into the FIFO, LSB first
module frame_sys_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W = 4,
  parameter int ALU_W = 16,
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic [DATA_W-1:0] rf_rd_data,
  input  logic              rf_rd_valid,
  output logic              alu_en,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [ALU_W-1:0]  alu_out,
  input  logic              alu_valid,
  output logic              clk_gate_en,
  output logic              clk_div_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_wr_inc,
  input  logic              fifo_full,
  output logic              frame_err,
  output logic [1:0]        err_code
);

  localparam int RES_BYTES = ALU_W / DATA_W;
  localparam int BC_W = $clog2(RES_BYTES + 1);
  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU = 8'hDD;
  localparam logic [7:0] CMD_BURST = 8'hEE;
  localparam logic [1:0] ERR_CMD = 2'd1;
  localparam logic [1:0] ERR_TO = 2'd2;
  localparam logic [1:0] ERR_OVR = 2'd3;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, GET_CNT,
    RF_WR, RF_RD, RF_WAIT, ALU_GATE, ALU_WAIT, PUSH
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0]  res_q, res_d;
  logic [BC_W-1:0]   bytes_q, bytes_d;
  logic              phase_q, phase_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              div_q;

  logic get_st, wait_st, timeout;

  assign get_st = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_OPA) ||
                  (state_q == GET_OPB) || (state_q == GET_FUN) || (state_q == GET_CNT);
  assign wait_st = get_st || (state_q == ALU_WAIT);
  assign timeout = wait_st && (to_q == TIMEOUT);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    opb_d      = opb_q;
    fun_d      = fun_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    bytes_d    = bytes_q;
    phase_d    = phase_q;
    to_d       = '0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    if (wait_st) to_d = to_q + TO_W'(1);
    // Timeout outranks a byte arriving in the same cycle; that byte is dropped.
    if (timeout) begin
      state_d    = IDLE;
      phase_d    = 1'b0;
      to_d       = '0;
      err_d      = 1'b1;
      err_code_d = ERR_TO;
    end else begin
      if (rx_valid && !get_st && (state_q != IDLE)) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVR;
      end
      if (rx_valid && get_st) to_d = '0;
      case (state_q)
        IDLE: if (rx_valid) begin
          cmd_d = rx_data[7:0];
          case (rx_data[7:0])
            CMD_WR, CMD_RD, CMD_BURST: state_d = GET_ADDR;
            CMD_ALU_OP:                state_d = GET_OPA;
            CMD_ALU:                   state_d = GET_FUN;
            default: begin
              err_d      = 1'b1;
              err_code_d = ERR_CMD;
            end
          endcase
        end
        GET_ADDR: if (rx_valid) begin
          addr_d = rx_data[ADDR_W-1:0];
          case (cmd_q)
            CMD_WR:    state_d = GET_DATA;
            CMD_BURST: state_d = GET_CNT;
            default: begin
              cnt_d   = DATA_W'(1);
              state_d = RF_RD;
            end
          endcase
        end
        GET_DATA: if (rx_valid) begin
          data_d  = rx_data;
          state_d = RF_WR;
        end
        GET_OPA: if (rx_valid) begin
          data_d  = rx_data;
          state_d = GET_OPB;
        end
        GET_OPB: if (rx_valid) begin
          opb_d   = rx_data;
          state_d = GET_FUN;
        end
        GET_FUN: if (rx_valid) begin
          fun_d   = rx_data[FUN_W-1:0];
          cnt_d   = '0;
          state_d = (cmd_q == CMD_ALU_OP) ? RF_WR : ALU_GATE;
        end
        GET_CNT: if (rx_valid) begin
          cnt_d   = rx_data;
          state_d = (rx_data == '0) ? IDLE : RF_RD;
        end
        RF_WR: begin
          if ((cmd_q == CMD_ALU_OP) && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            state_d = (cmd_q == CMD_ALU_OP) ? ALU_GATE : IDLE;
          end
        end
        RF_RD: state_d = RF_WAIT;
        RF_WAIT: if (rf_rd_valid) begin
          res_d   = ALU_W'(rf_rd_data);
          bytes_d = BC_W'(1);
          state_d = PUSH;
        end
        ALU_GATE: state_d = ALU_WAIT;
        ALU_WAIT: if (alu_valid) begin
          res_d   = alu_out;
          bytes_d = BC_W'(RES_BYTES);
          to_d    = '0;
          state_d = PUSH;
        end
        PUSH: if (!fifo_full) begin
          res_d   = res_q >> DATA_W;
          bytes_d = bytes_q - BC_W'(1);
          // cnt_q holds the reads still owed, including the one just pushed.
          if (bytes_q == BC_W'(1)) begin
            if (cnt_q > DATA_W'(1)) begin
              cnt_d   = cnt_q - DATA_W'(1);
              addr_d  = addr_q + ADDR_W'(1);
              state_d = RF_RD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      bytes_q    <= '0;
      phase_q    <= 1'b0;
      to_q       <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      div_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      bytes_q    <= bytes_d;
      phase_q    <= phase_d;
      to_q       <= to_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      div_q      <= 1'b1;
    end
  end

  assign rf_wr_en = (state_q == RF_WR);
  assign rf_rd_en = (state_q == RF_RD);
  assign rf_addr = ((state_q == RF_WR) && (cmd_q == CMD_ALU_OP)) ? ADDR_W'(phase_q) :
                   ((state_q == RF_WR) || (state_q == RF_RD)) ? addr_q : '0;
  assign rf_wr_data = (state_q != RF_WR) ? '0 :
                      ((cmd_q == CMD_ALU_OP) && phase_q) ? opb_q : data_q;
  assign clk_gate_en = (state_q == ALU_GATE) || (state_q == ALU_WAIT);
  assign alu_en = (state_q == ALU_WAIT);
  assign alu_fun = fun_q;
  assign fifo_wr_data = (state_q == PUSH) ? res_q[DATA_W-1:0] : '0;
  assign fifo_wr_inc = (state_q == PUSH) && !fifo_full;
  assign frame_err = err_q;
  assign err_code = err_code_q;
  assign clk_div_en = div_q;

endmodule

// File: tb/tb_frame_sys_ctrl.sv
// Randomised bench for frame_sys_ctrl: environment models for register file, ALU and FIFO,
// with expectations taken from a frame-level reference model.
module tb_frame_sys_ctrl;
  localparam int TMO = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rf_wr_en, rf_rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data = '0;
  logic       rf_rd_valid = 1'b0;
  logic       alu_en;
  logic [3:0] alu_fun;
  logic [15:0] alu_out = '0;
  logic       alu_valid = 1'b0;
  logic       clk_gate_en, clk_div_en;
  logic [7:0] fifo_wr_data;
  logic       fifo_wr_inc;
  logic       fifo_full = 1'b0;
  logic       frame_err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  frame_sys_ctrl #(.DATA_W(8), .ADDR_W(4), .FUN_W(4), .ALU_W(16), .TO_W(16), .TIMEOUT(16'd5000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_en(alu_en), .alu_fun(alu_fun),
    .alu_out(alu_out), .alu_valid(alu_valid), .clk_gate_en(clk_gate_en), .clk_div_en(clk_div_en),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_inc(fifo_wr_inc), .fifo_full(fifo_full),
    .frame_err(frame_err), .err_code(err_code)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] rf_mem [16];
  logic [7:0] exp_regs [16];
  logic [7:0] push_q [$];
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, inc_full_viol = 0, en_wo_gate = 0;
  int cyc = 0, gate_rise = -1, en_rise = -2, alu_en_cnt = 0, alu_lat = 2;
  logic [1:0] last_code = '0;
  logic [3:0] fun_seen = '0;
  logic gate_p = 1'b0, en_p = 1'b0, rd_req_s = 1'b0, alu_respond = 1'b1;
  logic [3:0] rd_addr_s = '0;
  logic [15:0] alu_res = '0;

  always @(negedge clk) begin
    cyc++;
    if (rf_wr_en) begin
      wr_cnt++;
      rf_mem[rf_addr] = rf_wr_data;
      wr_addr_q.push_back(rf_addr);
      wr_data_q.push_back(rf_wr_data);
    end
    if (rf_rd_en) rd_cnt++;
    rd_req_s = rf_rd_en;
    rd_addr_s = rf_addr;
    if (fifo_wr_inc) begin
      if (fifo_full) inc_full_viol++;
      else push_q.push_back(fifo_wr_data);
    end
    if (frame_err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (clk_gate_en && !gate_p) gate_rise = cyc;
    if (alu_en && !en_p) begin
      en_rise = cyc;
      fun_seen = alu_fun;
    end
    if (alu_en && !clk_gate_en) en_wo_gate++;
    gate_p = clk_gate_en;
    en_p = alu_en;
    if (alu_en) alu_en_cnt++;
    else alu_en_cnt = 0;
  end

  // Register file answers one cycle after the read strobe; ALU answers after alu_lat cycles of alu_en.
  always @(posedge clk) begin
    #1;
    rf_rd_valid = rd_req_s;
    rf_rd_data = rf_mem[rd_addr_s];
    alu_valid = alu_respond && en_p && (alu_en_cnt == alu_lat);
    alu_out = alu_res;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = '0;
  endtask

  task automatic clear_logs();
    push_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cnt = 0; rd_cnt = 0; err_cnt = 0; inc_full_viol = 0; en_wo_gate = 0;
    gate_rise = -1; en_rise = -2;
  endtask

  function automatic int q_diff(input logic [7:0] a [$], input logic [7:0] b [$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [15:0] out_vec();
    return {rf_wr_en, rf_rd_en, alu_en, clk_gate_en, fifo_wr_inc, frame_err, err_code,
            rf_wr_data | fifo_wr_data};
  endfunction

  task automatic test_reset();
    tick(3);
    n_checks++;
    if ({out_vec(), rf_addr, alu_fun, clk_div_en} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h/%h/%b required all zero", out_vec(), rf_addr, alu_fun, clk_div_en);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++;
    if (clk_div_en !== 1'b0) begin n_fail++; $display("FAIL div_before_edge: got %b required 0", clk_div_en); end
    tick(1);
    n_checks++;
    if (clk_div_en !== 1'b1) begin n_fail++; $display("FAIL div_after_edge: got %b required 1", clk_div_en); end
    tick(2);
    n_checks++;
    if ({out_vec(), rf_addr} !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h required 0", {out_vec(), rf_addr}); end
  endtask

  task automatic test_write();
    logic [7:0] ab, d;
    for (int it = 0; it < 6; it++) begin
      ab = (it == 0) ? 8'h05 : 8'($urandom);
      d  = (it == 0) ? 8'h3C : 8'($urandom);
      clear_logs();
      send_byte(8'hAA); send_byte(ab); send_byte(d);
      tick(5);
      exp_regs[ab[3:0]] = d;
      n_checks++;
      if (wr_cnt !== 1) begin n_fail++; $display("FAIL write_count: got %0d required 1", wr_cnt); end
      else begin
        n_checks++;
        if (wr_addr_q[0] !== ab[3:0] || wr_data_q[0] !== d) begin
          n_fail++; $display("FAIL write_addr_data: got %h/%h required %h/%h", wr_addr_q[0], wr_data_q[0], ab[3:0], d);
        end
      end
      n_checks++;
      if (push_q.size() !== 0 || err_cnt !== 0) begin
        n_fail++; $display("FAIL write_side_effects: got pushes %0d errs %0d required 0/0", push_q.size(), err_cnt);
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] ab;
    logic [7:0] exp_q [$];
    rf_mem[2] = 8'h81; exp_regs[2] = 8'h81;
    for (int it = 0; it < 5; it++) begin
      ab = (it == 0) ? 8'h02 : 8'($urandom);
      clear_logs();
      send_byte(8'hBB); send_byte(ab);
      tick(8);
      exp_q = '{exp_regs[ab[3:0]]};
      n_checks++;
      if (rd_cnt !== 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL read_strobes: got rd %0d wr %0d required 1/0", rd_cnt, wr_cnt); end
      n_checks++;
      if (q_diff(push_q, exp_q) !== -1) begin
        n_fail++; $display("FAIL read_push: got %0d bytes required 1 byte %h (addr %h)", push_q.size(), exp_q[0], ab[3:0]);
      end
    end
  endtask

  task automatic test_alu();
    logic [7:0] a, b, f;
    logic       with_ops;
    logic [7:0] exp_q [$];
    for (int it = 0; it < 6; it++) begin
      with_ops = (it % 2 == 0);
      a = (it == 0) ? 8'h0A : 8'($urandom);
      b = (it == 0) ? 8'h03 : 8'($urandom);
      f = (it == 0) ? 8'h00 : 8'($urandom);
      alu_res = (it == 0) ? 16'h000D : 16'($urandom);
      alu_lat = $urandom_range(1, 6);
      clear_logs();
      if (with_ops) begin
        send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
        exp_regs[0] = a; exp_regs[1] = b;
      end else begin
        send_byte(8'hDD); send_byte(f);
      end
      tick(25);
      n_checks++;
      if (wr_cnt !== (with_ops ? 2 : 0)) begin
        n_fail++; $display("FAIL alu_write_count: got %0d required %0d", wr_cnt, with_ops ? 2 : 0);
      end else if (with_ops) begin
        n_checks++;
        if (wr_addr_q[0] !== 4'd0 || wr_addr_q[1] !== 4'd1 || wr_data_q[0] !== a || wr_data_q[1] !== b) begin
          n_fail++; $display("FAIL alu_operands: got %h=%h %h=%h required 0=%h 1=%h",
                             wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], a, b);
        end
      end
      n_checks++;
      if (en_rise - gate_rise !== 1 || en_wo_gate !== 0) begin
        n_fail++; $display("FAIL alu_gate_order: got gate->en %0d cycles (en w/o gate %0d) required 1", en_rise - gate_rise, en_wo_gate);
      end
      n_checks++;
      if (fun_seen !== f[3:0]) begin n_fail++; $display("FAIL alu_fun: got %h required %h", fun_seen, f[3:0]); end
      exp_q = '{alu_res[7:0], alu_res[15:8]};
      n_checks++;
      if (q_diff(push_q, exp_q) !== -1) begin
        n_fail++; $display("FAIL alu_push: got %0d bytes required %h,%h", push_q.size(), exp_q[0], exp_q[1]);
      end
      n_checks++;
      if (alu_en !== 1'b0 || clk_gate_en !== 1'b0) begin
        n_fail++; $display("FAIL alu_release: got en %b gate %b required 0/0", alu_en, clk_gate_en);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] ab, n;
    logic [7:0] exp_q [$];
    int k;
    for (int it = 0; it < 4; it++) begin
      ab = (it == 0) ? 8'h0E : 8'($urandom);
      n  = (it == 0) ? 8'd3 : (it == 3) ? 8'd0 : 8'($urandom_range(1, 20));
      clear_logs();
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) exp_q.push_back(exp_regs[4'(ab[3:0] + i)]);
      send_byte(8'hEE); send_byte(ab); send_byte(n);
      if (it == 0) begin
        k = 0;
        while (push_q.size() < 1 && k < 50) begin tick(1); k++; end
        fifo_full = 1'b1;
        tick(10);
        n_checks++;
        if (push_q.size() !== 1) begin n_fail++; $display("FAIL burst_stall: got %0d bytes during stall required 1", push_q.size()); end
        fifo_full = 1'b0;
      end else if (n != 0) begin
        for (int c = 0; c < 120; c++) begin
          fifo_full = 1'($urandom_range(0, 1));
          tick(1);
        end
        fifo_full = 1'b0;
      end
      k = 0;
      while (push_q.size() < exp_q.size() && k < 200) begin tick(1); k++; end
      tick(6);
      n_checks++;
      if (q_diff(push_q, exp_q) !== -1) begin
        n_fail++; $display("FAIL burst_data: got %0d bytes required %0d (addr %h, first diff %0d)",
                           push_q.size(), exp_q.size(), ab[3:0], q_diff(push_q, exp_q));
      end
      n_checks++;
      if (rd_cnt !== int'(n) || inc_full_viol !== 0 || err_cnt !== 0) begin
        n_fail++; $display("FAIL burst_strobes: got rd %0d push-while-full %0d errs %0d required %0d/0/0",
                           rd_cnt, inc_full_viol, err_cnt, n);
      end
    end
  endtask

  task automatic test_unknown();
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      b = 8'h55;
      if (it != 0) begin
        b = 8'($urandom);
        while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE) b = 8'($urandom);
      end
      clear_logs();
      send_byte(b);
      tick(3);
      n_checks++;
      if (err_cnt !== 1 || last_code !== 2'd1 || err_code !== 2'd1) begin
        n_fail++; $display("FAIL unknown_cmd %h: got %0d pulses code %0d required 1 pulse code 1", b, err_cnt, last_code);
      end
      n_checks++;
      if (wr_cnt !== 0 || rd_cnt !== 0 || push_q.size() !== 0 || gate_rise !== -1) begin
        n_fail++; $display("FAIL unknown_side_effects: got wr %0d rd %0d push %0d required none", wr_cnt, rd_cnt, push_q.size());
      end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] ab, f;
    logic [7:0] exp_q [$];
    ab = 8'($urandom);
    clear_logs();
    fifo_full = 1'b1;
    send_byte(8'hBB); send_byte(ab);
    tick(6);
    send_byte(8'h77);
    tick(2);
    n_checks++;
    if (err_cnt !== 1 || last_code !== 2'd3 || push_q.size() !== 0) begin
      n_fail++; $display("FAIL overrun_push: got %0d pulses code %0d pushes %0d required 1/3/0", err_cnt, last_code, push_q.size());
    end
    fifo_full = 1'b0;
    tick(6);
    exp_q = '{exp_regs[ab[3:0]]};
    n_checks++;
    if (q_diff(push_q, exp_q) !== -1 || err_cnt !== 1 || err_code !== 2'd3) begin
      n_fail++; $display("FAIL overrun_intact: got %0d bytes errs %0d code %0d required 1 byte %h, 1, 3",
                         push_q.size(), err_cnt, err_code, exp_q[0]);
    end
    f = 8'($urandom);
    alu_res = 16'($urandom);
    alu_lat = 10;
    clear_logs();
    send_byte(8'hDD); send_byte(f);
    tick(2);
    send_byte(8'hBB);
    tick(25);
    exp_q = '{alu_res[7:0], alu_res[15:8]};
    n_checks++;
    if (q_diff(push_q, exp_q) !== -1 || err_cnt !== 1 || last_code !== 2'd3 || rd_cnt !== 0) begin
      n_fail++; $display("FAIL overrun_alu: got %0d bytes errs %0d code %0d rd %0d required 2 bytes, 1, 3, 0",
                         push_q.size(), err_cnt, last_code, rd_cnt);
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05);
    tick(TMO - 3);
    n_checks++;
    if (err_cnt !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d pulses required 0", err_cnt); end
    k = 0;
    while (err_cnt == 0 && k < 12) begin tick(1); k++; end
    tick(3);
    n_checks++;
    if (err_cnt !== 1 || last_code !== 2'd2 || wr_cnt !== 0) begin
      n_fail++; $display("FAIL timeout_frame: got %0d pulses code %0d writes %0d required 1/2/0", err_cnt, last_code, wr_cnt);
    end
    clear_logs();
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    tick(4);
    exp_regs[1] = 8'hFF;
    n_checks++;
    if (wr_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL timeout_recover: got writes %0d errs %0d required 1/0", wr_cnt, err_cnt);
    end else begin
      n_checks++;
      if (wr_addr_q[0] !== 4'h1 || wr_data_q[0] !== 8'hFF) begin
        n_fail++; $display("FAIL timeout_recover_data: got %h/%h required 1/ff", wr_addr_q[0], wr_data_q[0]);
      end
    end
    clear_logs();
    alu_respond = 1'b0;
    send_byte(8'hDD); send_byte(8'h03);
    tick(TMO + 8);
    n_checks++;
    if (err_cnt !== 1 || last_code !== 2'd2 || alu_en !== 1'b0 || clk_gate_en !== 1'b0 || push_q.size() !== 0) begin
      n_fail++; $display("FAIL alu_timeout: got %0d pulses code %0d en %b gate %b pushes %0d required 1/2/0/0/0",
                         err_cnt, last_code, alu_en, clk_gate_en, push_q.size());
    end
    alu_respond = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_byte(8'hAA); send_byte(8'h07);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_vec(), rf_addr, clk_div_en} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h required 0", {out_vec(), rf_addr, clk_div_en});
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_logs();
    send_byte(8'h3C);
    tick(3);
    n_checks++;
    if (wr_cnt !== 0 || err_cnt !== 1 || last_code !== 2'd1) begin
      n_fail++; $display("FAIL reset_mid_abandon: got writes %0d errs %0d code %0d required 0/1/1", wr_cnt, err_cnt, last_code);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 8'($urandom);
      exp_regs[i] = rf_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_alu();
    test_burst();
    test_unknown();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
